// File: rtl/upsample_stream.sv
// ---------------------------------------------------------------------------
// upsample_stream
//
// Streaming upsampler for the generator decoder path. A frame of IN_LEN
// packed multi-channel samples comes in and IN_LEN*FACTOR samples go out.
// In nearest mode each input is simply repeated FACTOR times. In linear mode
// each input is interpolated toward the following input, and the final input
// is repeated because it has no successor (edge replicate).
//
// Build option:
//   UPSAMPLE_LINEAR_EN  - when defined, linear mode is available: the nxt
//                         register, the have-current flag, the latched mode
//                         and the per-channel interpolator are built. When
//                         left undefined, the block is nearest-only and the
//                         mode input is ignored.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   start      in   frame start pulse, only honoured while idle
//   mode       in   0 = nearest, 1 = linear (latched on an accepted start)
//   data_in    in   packed input sample, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   valid_in   in   input valid
//   ready_in   out  input ready (high only while waiting for an input)
//   data_out   out  packed output sample, zero when not emitting
//   valid_out  out  output valid
//   ready_out  in   downstream ready
//   busy       out  high while a frame is being filled or emitted
//   done       out  one-cycle pulse after the last output transfer
// ---------------------------------------------------------------------------
module upsample_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4,
    parameter int IN_LEN     = 8,
    parameter int FACTOR     = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           mode,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           valid_in,
    output logic                           ready_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           valid_out,
    input  logic                           ready_out,
    output logic                           busy,
    output logic                           done
);

    localparam int BUS_W = CHANNELS * DATA_WIDTH;
    localparam int PH_W  = $clog2(FACTOR);
    localparam int CNT_W = $clog2(IN_LEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(FACTOR - 1);
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(IN_LEN - 1);

    logic [1:0]       state_q,  state_d;
    logic [BUS_W-1:0] cur_q,    cur_d;
    logic [PH_W-1:0]  phase_q,  phase_d;
    // Number of inputs whose FACTOR outputs have been fully emitted; reaching
    // IN_LEN-1 at a phase wrap means the frame is complete in either mode.
    logic [CNT_W-1:0] outCnt_q, outCnt_d;

`ifdef UPSAMPLE_LINEAR_EN
    localparam logic [CNT_W-1:0] ALL_INPUTS = CNT_W'(IN_LEN);
    localparam int               PROD_W     = DATA_WIDTH + 1 + PH_W;

    logic [BUS_W-1:0] nxt_q,     nxt_d;
    logic [CNT_W-1:0] inCnt_q,   inCnt_d;
    logic             haveCur_q, haveCur_d;
    logic             mode_q,    mode_d;
`endif

    logic inXfer;
    logic outXfer;
    logic [BUS_W-1:0] sample;

    // Handshake outputs are pure decodes of the state register, so ready_in
    // never depends combinationally on ready_out.
    assign ready_in  = (state_q == ST_FILL);
    assign valid_out = (state_q == ST_EMIT);
    assign busy      = (state_q == ST_FILL) || (state_q == ST_EMIT);
    assign done      = (state_q == ST_DONE);

    assign inXfer  = valid_in  && ready_in;
    assign outXfer = valid_out && ready_out;

    // Next-state and datapath register update.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        phase_d  = phase_q;
        outCnt_d = outCnt_q;
`ifdef UPSAMPLE_LINEAR_EN
        nxt_d     = nxt_q;
        inCnt_d   = inCnt_q;
        haveCur_d = haveCur_q;
        mode_d    = mode_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FILL;
                    phase_d  = '0;
                    outCnt_d = '0;
`ifdef UPSAMPLE_LINEAR_EN
                    inCnt_d   = '0;
                    haveCur_d = 1'b0;
                    mode_d    = mode;
`endif
                end
            end

            ST_FILL: begin
                if (inXfer) begin
`ifdef UPSAMPLE_LINEAR_EN
                    inCnt_d = inCnt_q + CNT_W'(1);
                    if (mode_q && haveCur_q) begin
                        nxt_d   = data_in;
                        state_d = ST_EMIT;
                    end else begin
                        cur_d = data_in;
                        if (mode_q) begin
                            // Linear needs a pair before it can emit, except
                            // for a one-sample frame which interpolates toward
                            // itself.
                            haveCur_d = 1'b1;
                            if (IN_LEN == 1) begin
                                nxt_d   = data_in;
                                state_d = ST_EMIT;
                            end
                        end else begin
                            state_d = ST_EMIT;
                        end
                    end
`else
                    cur_d   = data_in;
                    state_d = ST_EMIT;
`endif
                end
            end

            ST_EMIT: begin
                if (outXfer) begin
                    if (phase_q == PHASE_LAST) begin
                        phase_d  = '0;
                        outCnt_d = outCnt_q + CNT_W'(1);
                        if (outCnt_q == LAST_GROUP) begin
                            state_d = ST_DONE;
`ifdef UPSAMPLE_LINEAR_EN
                        end else if (mode_q) begin
                            // Slide the pair forward. Once every input is in,
                            // nxt keeps the last sample so the final group is
                            // a flat replicate with no fill bubble.
                            cur_d = nxt_q;
                            if (inCnt_q != ALL_INPUTS) begin
                                state_d = ST_FILL;
                            end
`endif
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            phase_q  <= '0;
            outCnt_q <= '0;
`ifdef UPSAMPLE_LINEAR_EN
            nxt_q     <= '0;
            inCnt_q   <= '0;
            haveCur_q <= 1'b0;
            mode_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            phase_q  <= phase_d;
            outCnt_q <= outCnt_d;
`ifdef UPSAMPLE_LINEAR_EN
            nxt_q     <= nxt_d;
            inCnt_q   <= inCnt_d;
            haveCur_q <= haveCur_d;
            mode_q    <= mode_d;
`endif
        end
    end

`ifdef UPSAMPLE_LINEAR_EN
    // Per-channel interpolator: out = cur + floor((nxt - cur) * phase / FACTOR).
    // The difference needs one extra bit to cover the full signed range, and
    // the product needs log2(FACTOR) more. The result always lies between cur
    // and nxt, so keeping only the low DATA_WIDTH bits of the sum is exact.
    logic [BUS_W-1:0] interp;

    for (genvar c = 0; c < CHANNELS; c++) begin : gInterp
        logic signed [DATA_WIDTH-1:0] curS;
        logic signed [DATA_WIDTH-1:0] nxtS;
        logic signed [DATA_WIDTH:0]   diff;
        logic signed [PROD_W-1:0]     diffExt;
        logic signed [PROD_W-1:0]     phaseExt;
        logic signed [PROD_W-1:0]     prod;
        logic signed [PROD_W-1:0]     scaled;
        logic                         unused_scaled;

        assign curS     = cur_q[c*DATA_WIDTH +: DATA_WIDTH];
        assign nxtS     = nxt_q[c*DATA_WIDTH +: DATA_WIDTH];
        assign diff     = {nxtS[DATA_WIDTH-1], nxtS} - {curS[DATA_WIDTH-1], curS};
        assign diffExt  = {{PH_W{diff[DATA_WIDTH]}}, diff};
        assign phaseExt = {{(DATA_WIDTH + 1){1'b0}}, phase_q};
        assign prod     = diffExt * phaseExt;
        // Arithmetic shift floors toward minus infinity for negative steps.
        assign scaled   = prod >>> PH_W;

        assign interp[c*DATA_WIDTH +: DATA_WIDTH] = curS + scaled[DATA_WIDTH-1:0];
        assign unused_scaled = ^scaled[PROD_W-1:DATA_WIDTH];
    end

    assign sample = mode_q ? interp : cur_q;
`else
    logic unused_mode;

    assign sample      = cur_q;
    assign unused_mode = mode;
`endif

    // The output bus is forced to zero whenever no sample is being offered.
    assign data_out = (state_q == ST_EMIT) ? sample : '0;

endmodule

// File: tb/tb_upsample_stream.sv
// ---------------------------------------------------------------------------
// tb_upsample_stream
//
// Directed bench for upsample_stream. Three instances share one clock and
// reset: u0 (FACTOR=2, IN_LEN=4), u1 (FACTOR=4, IN_LEN=2) and
// u2 (FACTOR=4, IN_LEN=1). Expected output tables are hand-computed; when
// UPSAMPLE_LINEAR_EN is not defined the linear-mode runs expect the
// nearest-mode tables.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_upsample_stream;

    localparam int DW = 16;
    localparam int CH = 4;
    localparam int BW = DW * CH;

`ifdef UPSAMPLE_LINEAR_EN
    localparam bit LINEAR_BUILT = 1'b1;
`else
    localparam bit LINEAR_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstN;
    logic          startS    [3];
    logic          modeS     [3];
    logic [BW-1:0] dataInS   [3];
    logic          validInS  [3];
    logic          readyInS  [3];
    logic [BW-1:0] dataOutS  [3];
    logic          validOutS [3];
    logic          readyOutS [3];
    logic          busyS     [3];
    logic          doneS     [3];

    int vectors     = 0;
    int miscompares = 0;

    logic [BW-1:0] frameIn [4];
    logic [BW-1:0] expOut  [8];

    always #5 clk = ~clk;

    upsample_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .IN_LEN(4), .FACTOR(2)) u0 (
        .clk(clk), .rst_n(rstN), .start(startS[0]), .mode(modeS[0]),
        .data_in(dataInS[0]), .valid_in(validInS[0]), .ready_in(readyInS[0]),
        .data_out(dataOutS[0]), .valid_out(validOutS[0]), .ready_out(readyOutS[0]),
        .busy(busyS[0]), .done(doneS[0])
    );

    upsample_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .IN_LEN(2), .FACTOR(4)) u1 (
        .clk(clk), .rst_n(rstN), .start(startS[1]), .mode(modeS[1]),
        .data_in(dataInS[1]), .valid_in(validInS[1]), .ready_in(readyInS[1]),
        .data_out(dataOutS[1]), .valid_out(validOutS[1]), .ready_out(readyOutS[1]),
        .busy(busyS[1]), .done(doneS[1])
    );

    upsample_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .IN_LEN(1), .FACTOR(4)) u2 (
        .clk(clk), .rst_n(rstN), .start(startS[2]), .mode(modeS[2]),
        .data_in(dataInS[2]), .valid_in(validInS[2]), .ready_in(readyInS[2]),
        .data_out(dataOutS[2]), .valid_out(validOutS[2]), .ready_out(readyOutS[2]),
        .busy(busyS[2]), .done(doneS[2])
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                               input logic [BW-1:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // u0 frame: channels {ch3, ch2, ch1, ch0}
    task automatic loadFrameU0(input bit interp);
        frameIn[0] = 64'h8000_0400_FF00_0100;
        frameIn[1] = 64'h7FFF_0300_FE00_0200;
        frameIn[2] = 64'h0000_0200_FD00_0300;
        frameIn[3] = 64'hFFFF_0100_FC00_0400;
        if (interp && LINEAR_BUILT) begin
            expOut[0] = 64'h8000_0400_FF00_0100;
            expOut[1] = 64'hFFFF_0380_FE80_0180;
            expOut[2] = 64'h7FFF_0300_FE00_0200;
            expOut[3] = 64'h3FFF_0280_FD80_0280;
            expOut[4] = 64'h0000_0200_FD00_0300;
            expOut[5] = 64'hFFFF_0180_FC80_0380;
            expOut[6] = 64'hFFFF_0100_FC00_0400;
            expOut[7] = 64'hFFFF_0100_FC00_0400;
        end else begin
            expOut[0] = 64'h8000_0400_FF00_0100;
            expOut[1] = 64'h8000_0400_FF00_0100;
            expOut[2] = 64'h7FFF_0300_FE00_0200;
            expOut[3] = 64'h7FFF_0300_FE00_0200;
            expOut[4] = 64'h0000_0200_FD00_0300;
            expOut[5] = 64'h0000_0200_FD00_0300;
            expOut[6] = 64'hFFFF_0100_FC00_0400;
            expOut[7] = 64'hFFFF_0100_FC00_0400;
        end
    endtask

    // Runs one frame on instance w, checking every output transfer, the hold
    // behaviour under backpressure, throughput and the done/busy handoff.
    task automatic applyStimulus(input string tag, input int w, input int nIn,
                                 input int nOut, input logic modeSel, input bit stall,
                                 input bit pulseStart, input int expCycles);
        int            inIdx   = 0;
        int            outIdx  = 0;
        int            cycles  = 0;
        bit            inX     = 1'b0;
        bit            outX    = 1'b0;
        bit            holding = 1'b0;
        logic [BW-1:0] held    = '0;

        @(negedge clk);
        startS[w] = 1'b1;
        modeS[w]  = modeSel;
        @(negedge clk);
        startS[w] = 1'b0;
        checkOutput({tag, " busy"}, busyS[w], 1'b1);

        while (outIdx < nOut && cycles < 400) begin
            if (holding) begin
                checkOutput($sformatf("%s hold valid c%0d", tag, cycles), validOutS[w], 1'b1);
                checkOutput($sformatf("%s hold data c%0d", tag, cycles), dataOutS[w], held);
            end
            if (pulseStart && cycles == 4) begin
                startS[w] = 1'b1;
                modeS[w]  = ~modeSel;
            end else begin
                startS[w] = 1'b0;
                modeS[w]  = modeSel;
            end
            if (inIdx < nIn) begin
                validInS[w] = 1'b1;
                dataInS[w]  = frameIn[inIdx];
            end else begin
                validInS[w] = 1'b0;
                dataInS[w]  = '0;
            end
            readyOutS[w] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            inX  = validInS[w] && readyInS[w];
            outX = validOutS[w] && readyOutS[w];
            if (outX) begin
                checkOutput($sformatf("%s out%0d", tag, outIdx), dataOutS[w], expOut[outIdx]);
                outIdx++;
            end
            holding = validOutS[w] && !readyOutS[w];
            held    = dataOutS[w];
            cycles++;
            @(posedge clk);
            if (inX) inIdx++;
            @(negedge clk);
        end

        startS[w]    = 1'b0;
        modeS[w]     = modeSel;
        validInS[w]  = 1'b0;
        dataInS[w]   = '0;
        readyOutS[w] = 1'b1;

        checkOutput({tag, " outputs seen"}, outIdx, nOut);
        checkOutput({tag, " inputs taken"}, inIdx, nIn);
        if (!stall) checkOutput({tag, " cycles"}, cycles, expCycles);
        checkOutput({tag, " done pulse"}, doneS[w], 1'b1);
        checkOutput({tag, " busy low"}, busyS[w], 1'b0);
        @(negedge clk);
        checkOutput({tag, " done cleared"}, doneS[w], 1'b0);
    endtask

    initial begin
        int  rIdx;
        bit  reached;
        bit  inX;

        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            startS[i]    = 1'b0;
            modeS[i]     = 1'b0;
            dataInS[i]   = '0;
            validInS[i]  = 1'b0;
            readyOutS[i] = 1'b1;
        end

        #12;
        checkOutput("reset ready_in", readyInS[0], 1'b0);
        checkOutput("reset valid_out", validOutS[0], 1'b0);
        checkOutput("reset data_out", dataOutS[0], '0);
        checkOutput("reset busy", busyS[0], 1'b0);
        checkOutput("reset done", doneS[0], 1'b0);
        checkOutput("reset u2 valid_out", validOutS[2], 1'b0);
        @(negedge clk);
        rstN = 1'b1;

        // Inputs offered while idle are never accepted.
        validInS[0] = 1'b1;
        dataInS[0]  = 64'h1234;
        repeat (3) @(negedge clk);
        checkOutput("idle ready_in", readyInS[0], 1'b0);
        checkOutput("idle valid_out", validOutS[0], 1'b0);
        checkOutput("idle busy", busyS[0], 1'b0);
        validInS[0] = 1'b0;
        dataInS[0]  = '0;

        loadFrameU0(1'b0);
        applyStimulus("near", 0, 4, 8, 1'b0, 1'b0, 1'b0, 12);

        loadFrameU0(1'b1);
        applyStimulus("lin", 0, 4, 8, 1'b1, 1'b0, 1'b0, 12);
        applyStimulus("lin stall", 0, 4, 8, 1'b1, 1'b1, 1'b1, 12);

        loadFrameU0(1'b0);
        applyStimulus("near stall", 0, 4, 8, 1'b0, 1'b1, 1'b1, 12);

        // Reset while the third input is being emitted.
        @(negedge clk);
        startS[0] = 1'b1;
        modeS[0]  = 1'b0;
        @(negedge clk);
        startS[0] = 1'b0;
        rIdx      = 0;
        reached   = 1'b0;
        for (int g = 0; g < 100 && !reached; g++) begin
            if (rIdx == 3 && validOutS[0]) begin
                reached = 1'b1;
            end else begin
                validInS[0]  = 1'b1;
                dataInS[0]   = frameIn[rIdx[1:0]];
                readyOutS[0] = 1'b1;
                inX = validInS[0] && readyInS[0];
                @(posedge clk);
                if (inX) rIdx++;
                @(negedge clk);
            end
        end
        checkOutput("midrst reached", reached, 1'b1);
        checkOutput("midrst pre data", dataOutS[0], 64'h0000_0200_FD00_0300);
        rstN        = 1'b0;
        validInS[0] = 1'b0;
        dataInS[0]  = '0;
        #1;
        checkOutput("midrst valid_out", validOutS[0], 1'b0);
        checkOutput("midrst data_out", dataOutS[0], '0);
        checkOutput("midrst ready_in", readyInS[0], 1'b0);
        checkOutput("midrst busy", busyS[0], 1'b0);
        checkOutput("midrst done", doneS[0], 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus("near after rst", 0, 4, 8, 1'b0, 1'b0, 1'b0, 12);

        // FACTOR=4 ramp 0x0100 -> 0x0200 on ch0.
        frameIn[0] = 64'h0000_0000_0000_0100;
        frameIn[1] = 64'h0000_0000_0000_0200;
        if (LINEAR_BUILT) begin
            expOut[0] = 64'h0100;
            expOut[1] = 64'h0140;
            expOut[2] = 64'h0180;
            expOut[3] = 64'h01C0;
        end else begin
            expOut[0] = 64'h0100;
            expOut[1] = 64'h0100;
            expOut[2] = 64'h0100;
            expOut[3] = 64'h0100;
        end
        expOut[4] = 64'h0200;
        expOut[5] = 64'h0200;
        expOut[6] = 64'h0200;
        expOut[7] = 64'h0200;
        applyStimulus("f4 lin", 1, 2, 8, 1'b1, 1'b0, 1'b0, 10);

        // One-sample frame: FACTOR copies of the only input.
        frameIn[0] = 64'h0000_0000_FD00_0300;
        for (int i = 0; i < 4; i++) expOut[i] = 64'h0000_0000_FD00_0300;
        applyStimulus("len1 lin", 2, 1, 4, 1'b1, 1'b0, 1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
